// File: rtl/bicolor_led_drv.sv
// Bicolor (anti-parallel red/green) LED driver: frame-based PWM brightness,
// amber by alternating polarity per frame, optional whole-frame blink gating.
module bicolor_led_drv #(
    parameter int PSC        = 4,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          code,
    input  logic [PWM_BITS-1:0] bright,
    input  logic                blink,
    output logic [1:0]          pkgpin
);

    localparam int PSC_W = (PSC > 1) ? $clog2(PSC) : 1;

    localparam logic [PSC_W-1:0]    PSC_LAST = PSC_W'(PSC - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = {PWM_BITS{1'b1}};

    localparam logic [1:0] CODE_OFF   = 2'b00;
    localparam logic [1:0] CODE_RED   = 2'b01;
    localparam logic [1:0] CODE_GREEN = 2'b10;
    localparam logic [1:0] CODE_AMBER = 2'b11;

    localparam logic [1:0] PIN_DARK  = 2'b00;
    localparam logic [1:0] PIN_RED   = 2'b01;
    localparam logic [1:0] PIN_GREEN = 2'b10;

    logic [PSC_W-1:0]      psc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  phase;

    logic [1:0]            code_sh;
    logic [PWM_BITS-1:0]   bright_sh;
    logic                  blink_sh;

    logic                  tick;
    logic                  frame_end;
    logic                  blink_dark;
    logic                  on;
    logic [1:0]            drive;

    assign tick      = (psc_cnt == PSC_LAST);
    assign frame_end = tick && (pwm_cnt == PWM_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_cnt <= '0;
        end else if (tick) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Everything that may change what the LED shows is updated only here,
    // so a frame is never altered part-way through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            code_sh   <= CODE_OFF;
            bright_sh <= '0;
            blink_sh  <= 1'b0;
        end else if (frame_end) begin
            blink_cnt <= blink_cnt + BLINK_BITS'(1);
            phase     <= ~phase;
            code_sh   <= code;
            bright_sh <= bright;
            blink_sh  <= blink;
        end
    end

    assign blink_dark = blink_sh && blink_cnt[BLINK_BITS-1];
    assign on         = (pwm_cnt < bright_sh) && !blink_dark;

    // Only one pin is ever driven high; 2'b11 is unreachable by construction.
    always_comb begin
        drive = PIN_DARK;
        if (on) begin
            case (code_sh)
                CODE_RED:   drive = PIN_RED;
                CODE_GREEN: drive = PIN_GREEN;
                CODE_AMBER: drive = phase ? PIN_GREEN : PIN_RED;
                default:    drive = PIN_DARK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkgpin <= PIN_DARK;
        end else begin
            pkgpin <= drive;
        end
    end

endmodule

// File: tb/tb_bicolor_led_drv.sv
// Directed bench for bicolor_led_drv: per-frame vector table (PSC=2, 32-clk
// frames, 4-frame blink period) plus reset, mid-frame update and PSC=1 checks.
module tb_bicolor_led_drv;

    typedef struct {
        logic [1:0] code;
        logic [3:0] bright;
        logic       blink;
        int         n01;
        int         n10;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] code;
    logic [3:0] bright;
    logic       blink;
    logic [1:0] pkgpin;
    logic [1:0] code1;
    logic [3:0] bright1;
    logic       blink1;
    logic [1:0] pkgpin1;

    int checks;
    int failures;
    int cyc;

    vec_t vecs[20];

    bicolor_led_drv #(.PSC(2), .PWM_BITS(4), .BLINK_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .code(code), .bright(bright),
        .blink(blink), .pkgpin(pkgpin)
    );

    bicolor_led_drv #(.PSC(1), .PWM_BITS(4), .BLINK_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .code(code1), .bright(bright1),
        .blink(blink1), .pkgpin(pkgpin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        code   = v.code;
        bright = v.bright;
        blink  = v.blink;
    endtask

    // One clock: sample mid-cycle. dut1 (16-clk frames, red, bright=4) is
    // checked over its first four output frames after each reset release.
    task automatic step();
        int f;
        int pos;
        logic [1:0] exp1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc <= 64) begin
            f    = (cyc - 1) / 16;
            pos  = (cyc - 1) % 16;
            exp1 = (f >= 1 && pos < 4) ? 2'b01 : 2'b00;
            check($sformatf("psc1_cyc%0d", cyc), int'(pkgpin1), int'(exp1));
        end
    endtask

    // Samples one 32-clk output frame; next vector is applied mid-frame.
    task automatic measure_frame(input int fid, input int e01, input int e10,
                                 input bit has_next, input vec_t nxt);
        int n01;
        int n10;
        int n11;
        int lead;
        bit run;
        n01  = 0;
        n10  = 0;
        n11  = 0;
        lead = 0;
        run  = 1'b1;
        for (int s = 0; s < 32; s++) begin
            step();
            if (s == 15 && has_next) apply(nxt);
            if (pkgpin == 2'b01) n01++;
            if (pkgpin == 2'b10) n10++;
            if (pkgpin == 2'b11) n11++;
            if (pkgpin == 2'b00) run = 1'b0;
            else if (run) lead++;
        end
        check($sformatf("frame%0d_red_clks", fid), n01, e01);
        check($sformatf("frame%0d_green_clks", fid), n10, e10);
        check($sformatf("frame%0d_both_high_clks", fid), n11, 0);
        check($sformatf("frame%0d_lit_at_start", fid), lead, e01 + e10);
    endtask

    initial begin
        vec_t dark;
        checks   = 0;
        failures = 0;
        cyc      = 0;

        // Frame f below is the f-th output frame after reset release.
        // Amber: even f -> red, odd f -> green. Blink: dark when f%4 is 2 or 3.
        vecs[0]  = '{2'b01, 4'd15, 1'b0, 30, 0};   // f1 red full
        vecs[1]  = '{2'b01, 4'd8,  1'b0, 16, 0};   // f2 red half
        vecs[2]  = '{2'b01, 4'd8,  1'b0, 16, 0};   // f3
        vecs[3]  = '{2'b11, 4'd15, 1'b0, 30, 0};   // f4 amber even
        vecs[4]  = '{2'b11, 4'd15, 1'b0, 0, 30};   // f5 amber odd
        vecs[5]  = '{2'b11, 4'd15, 1'b0, 30, 0};   // f6
        vecs[6]  = '{2'b00, 4'd15, 1'b0, 0, 0};    // f7 off
        vecs[7]  = '{2'b10, 4'd15, 1'b1, 0, 30};   // f8 blink lit
        vecs[8]  = '{2'b10, 4'd15, 1'b1, 0, 30};   // f9 blink lit
        vecs[9]  = '{2'b10, 4'd15, 1'b1, 0, 0};    // f10 blink dark
        vecs[10] = '{2'b10, 4'd15, 1'b1, 0, 0};    // f11 blink dark
        vecs[11] = '{2'b10, 4'd15, 1'b1, 0, 30};   // f12 blink lit again
        vecs[12] = '{2'b10, 4'd0,  1'b0, 0, 0};    // f13 bright 0
        vecs[13] = '{2'b11, 4'd0,  1'b0, 0, 0};    // f14 bright 0 amber
        vecs[14] = '{2'b01, 4'd1,  1'b0, 2, 0};    // f15 minimum duty
        vecs[15] = '{2'b11, 4'd3,  1'b1, 6, 0};    // f16 amber+blink lit even
        vecs[16] = '{2'b11, 4'd3,  1'b1, 0, 6};    // f17 amber+blink lit odd
        vecs[17] = '{2'b01, 4'd15, 1'b0, 30, 0};   // f18 red, then switched mid-frame
        vecs[18] = '{2'b10, 4'd0,  1'b0, 0, 0};    // f19 fully dark
        vecs[19] = '{2'b01, 4'd15, 1'b0, 30, 0};   // f20 red

        dark    = '{2'b00, 4'd0, 1'b0, 0, 0};
        rst_n   = 1'b0;
        code    = 2'b01;
        bright  = 4'd15;
        blink   = 1'b0;
        code1   = 2'b01;
        bright1 = 4'd4;
        blink1  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pkgpin", int'(pkgpin), 0);
        check("reset_pkgpin_psc1", int'(pkgpin1), 0);
        rst_n = 1'b1;
        cyc   = 0;

        measure_frame(0, 0, 0, 1'b1, vecs[0]);
        for (int i = 0; i < 20; i++) begin
            measure_frame(i + 1, vecs[i].n01, vecs[i].n10, (i < 19), (i < 19) ? vecs[i + 1] : dark);
        end

        // Frame 21 starts red; reset must darken the pins without a clock edge.
        @(posedge clk);
        #1;
        check("pre_reset_red", int'(pkgpin), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_pkgpin", int'(pkgpin), 0);
        check("async_reset_pkgpin_psc1", int'(pkgpin1), 0);
        @(posedge clk);
        #1;
        check("held_reset_pkgpin", int'(pkgpin), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Counters restart from zero: one dark frame, then red aligned to frame start.
        measure_frame(100, 0, 0, 1'b0, dark);
        measure_frame(101, 30, 0, 1'b0, dark);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bicolor_led_drv.md
Name: bicolor_led_drv

Overview:
Front-panel output counterpart of the 3-position toggle input. It drives a two-pin, two-lead bicolor LED (red/green, anti-parallel) from a 2-bit colour code. Amber is produced by alternating polarity on successive frames. Brightness comes from per-frame PWM, and an optional blink gates whole frames. Sits between the panel/UI register logic and two package output pins.

Parameters:
PSC, 4, prescaler divide; one PWM tick every PSC clocks (PSC >= 1)
PWM_BITS, 4, PWM counter width; frame = 2^PWM_BITS ticks
BLINK_BITS, 5, frame counter width; blink period = 2^BLINK_BITS frames

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
code  input  2  colour: 00 off, 01 red, 10 green, 11 amber
bright  input  PWM_BITS  duty, in ticks per frame
blink  input  1  1 = enable blink gating
pkgpin  output  2  LED drive, registered: 01 red (pin0 high), 10 green (pin1 high), 00 dark

Behaviour:
- Reset (async assert, sync release in the clk domain): prescaler, pwm_cnt, blink_cnt, phase, all shadow registers and pkgpin = 0. LED dark until the first frame boundary after reset.
- Prescaler:
  - counts 0..PSC-1.
  - tick = 1 when count == PSC-1, then count wraps to 0.
  - PSC=1: tick every clock.
- pwm_cnt:
  - advances by 1 on each tick.
  - wraps from 2^PWM_BITS-1 to 0.
- Frame boundary = tick while pwm_cnt == 2^PWM_BITS-1. At that clock:
  - code, bright, blink are copied into shadow registers.
  - phase toggles.
  - blink_cnt increments and wraps.
- Inputs are sampled only at frame boundaries. Mid-frame changes are invisible until the next boundary, which guarantees glitch-free PWM.
- on = (pwm_cnt < bright_sh) AND NOT (blink_sh AND blink_cnt[BLINK_BITS-1]):
  - bright_sh=0 gives fully dark.
  - Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- Drive value:
  - on=0 or code_sh=00: 00.
  - code_sh=01: 01.
  - code_sh=10: 10.
  - code_sh=11: 01 when phase=0, 10 when phase=1.
- pkgpin is registered from the current counter/shadow state, so output lags counter state by 1 clock.
- Invariant: pkgpin never equals 11, in any state, including reset release and mid-frame code changes.
- Polarity reversal in amber happens only at frame boundaries, never mid-frame.
- Reset mid-frame: pkgpin forces to 00 immediately (async). Counters restart from 0 on release.

Test Plan:
- Reset/idle: hold rst_n=0 with code=01, bright=15 → pkgpin=00. After release, pkgpin=00 for the first full frame (32 clks at PSC=2, PWM_BITS=4), then red.
- Red duty: PSC=2, PWM_BITS=4, code=01, bright=8, blink=0 → each 32-clk frame shows pkgpin=01 for 16 clks then 00 for 16 clks; never 10 or 11.
- Amber alternation: code=11, bright=15 → frame N shows 01 for 30 clks, frame N+1 shows 10 for 30 clks, repeating; no 11 observed on any clock.
- Blink: BLINK_BITS=2, code=10, bright=15, blink=1 → 2 frames lit (10) then 2 frames dark (00), period 128 clks.
- Mid-frame update: change code 01→10 and bright 15→0 halfway through a frame → current frame completes as red; next frame fully dark.
- Edge values:
  - PSC=1: frame = 16 clks.
  - bright=0: pkgpin stays 00 indefinitely for any code.
  - Assert rst_n low mid-pulse: pkgpin drops to 00 within the same clock, asynchronously.
